// File: rtl/mem_req_queue.sv
// Request FIFO in front of a memory controller: writes stream back-to-back, reads allow one outstanding.
// Optional read-abort timer is enabled by defining MEMQ_RD_TIMEOUT_EN.
module mem_req_queue #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    mc_valid,
    input  logic                    mc_ready,
    output logic                    mc_write,
    output logic [ADDR_W-1:0]       mc_addr,
    output logic [DATA_W-1:0]       mc_wdata,
    input  logic                    mc_rvalid,
    input  logic [DATA_W-1:0]       mc_rdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic              fifo_write [DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push;
    logic pop;
    logic head_write;
    logic rd_done;
    logic rd_abort;

    assign req_ready  = (count != CNT_W'(DEPTH));
    assign push       = req_valid && req_ready;
    assign pop        = mc_valid && mc_ready;
    assign head_write = fifo_write[rd_ptr];
    assign rd_done    = (state == WAIT_RD) && mc_rvalid;

    // Entry storage carries no reset: only occupied slots are ever presented.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= req_write;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (mc_ready) begin
                    if (head_write) begin
                        // count still includes the entry popped this cycle
                        next_state = (count > CNT_W'(1)) ? ISSUE : IDLE;
                    end else begin
                        next_state = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (rd_done || rd_abort) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Head fields are gated so the controller sees zeros whenever nothing is offered.
    always_comb begin
        mc_valid = 1'b0;
        mc_write = 1'b0;
        mc_addr  = '0;
        mc_wdata = '0;
        if (state == ISSUE) begin
            mc_valid = 1'b1;
            mc_write = fifo_write[rd_ptr];
            mc_addr  = fifo_addr[rd_ptr];
            mc_wdata = fifo_wdata[rd_ptr];
        end
    end

    // Response stage: data and pulse land one cycle after mc_rvalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_done;
            if (rd_done) begin
                rsp_data <= mc_rdata;
            end
        end
    end

`ifdef MEMQ_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             rsp_err_q;

    // A read return on the expiry edge takes priority over the abort.
    assign rd_abort = (state == WAIT_RD) && !mc_rvalid &&
                      (tmo_cnt == TMO_W'(RD_TIMEOUT - 1));
    assign rsp_err  = rsp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rd_abort;
            if ((state == WAIT_RD) && !mc_rvalid && !rd_abort) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    logic cfg_unused;

    assign rd_abort   = 1'b0;
    assign rsp_err    = 1'b0;
    assign cfg_unused = (RD_TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Self-checking bench for mem_req_queue: directed scenarios then randomized traffic
// compared against a queue-based reference model.
module tb_mem_req_queue;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 4;
    localparam int RD_TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              mc_valid;
    logic              mc_ready = 1'b0;
    logic              mc_write;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_wdata;
    logic              mc_rvalid = 1'b0;
    logic [DATA_W-1:0] mc_rdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    mem_req_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_write(mc_write),
        .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_rvalid(mc_rvalid), .mc_rdata(mc_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .count(count)
    );

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } req_t;

    req_t q[$];
    req_t ent;

    int vectors = 0;
    int miscompares = 0;
    int n;
    int errs;
    int valids;
    int stall;
    bit rd_out;
    bit exp_rsp;
    bit do_push;
    bit do_pop;
    logic [DATA_W-1:0] exp_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int k = 0;
        while (mc_valid !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        chk(tag, mc_valid, 1'b1);
    endtask

    task automatic set_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        // Reset state, checked while reset is still asserted
        #12;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_mc_valid", mc_valid, 1'b0);
        chk("rst_mc_addr", mc_addr, 0);
        chk("rst_mc_wdata", mc_wdata, 0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", req_ready, 1'b1);

        // Single write with minimum latency
        mc_ready = 1'b1;
        set_req(1'b1, 32'h10, 32'hCAFE);
        tick();
        req_valid = 1'b0;
        chk("wr_count1", count, 1);
        chk("wr_lat_low", mc_valid, 1'b0);
        tick();
        chk("wr_mc_valid", mc_valid, 1'b1);
        chk("wr_mc_write", mc_write, 1'b1);
        chk("wr_mc_addr", mc_addr, 32'h10);
        chk("wr_mc_wdata", mc_wdata, 32'hCAFE);
        tick();
        chk("wr_count0", count, 0);
        chk("wr_mc_idle", mc_valid, 1'b0);

        // Single read with response three cycles after issue
        set_req(1'b0, 32'h20, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("rd_mc_valid", mc_valid, 1'b1);
        chk("rd_mc_write", mc_write, 1'b0);
        chk("rd_mc_addr", mc_addr, 32'h20);
        tick();
        mc_ready = 1'b0;
        chk("rd_wait_mcv", mc_valid, 1'b0);
        chk("rd_count0", count, 0);
        tick();
        chk("rd_no_rsp_yet", rsp_valid, 1'b0);
        tick();
        mc_rvalid = 1'b1;
        mc_rdata  = 32'h1234;
        tick();
        mc_rvalid = 1'b0;
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_data", rsp_data, 32'h1234);
        tick();
        chk("rd_rsp_pulse", rsp_valid, 1'b0);

        // Fill to full with the controller stalled, then drain back-to-back
        for (int k = 0; k < 5; k++) begin
            set_req(1'b1, 32'h100 + k * 4, 32'hA0 + k);
            chk("fill_ready", req_ready, (k < 4));
            tick();
        end
        req_valid = 1'b0;
        chk("fill_count", count, 4);
        chk("fill_ready_full", req_ready, 1'b0);
        chk("fill_hold_addr", mc_addr, 32'h100);
        mc_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_valid", mc_valid, 1'b1);
            chk("drain_addr", mc_addr, 32'h100 + k * 4);
            chk("drain_wdata", mc_wdata, 32'hA0 + k);
            tick();
        end
        mc_ready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_idle", mc_valid, 1'b0);

        // Simultaneous push and pop at count 2, pointers wrap
        for (int k = 0; k < 2; k++) begin
            set_req(1'b1, 32'h200 + k, 32'hB00 + k);
            tick();
        end
        req_valid = 1'b0;
        chk("pp_count2", count, 2);
        chk("pp_issue", mc_valid, 1'b1);
        mc_ready = 1'b1;
        for (int k = 2; k < 8; k++) begin
            set_req(1'b1, 32'h200 + k, 32'hB00 + k);
            chk("pp_addr", mc_addr, 32'h200 + k - 2);
            chk("pp_wdata", mc_wdata, 32'hB00 + k - 2);
            tick();
            chk("pp_count_hold", count, 2);
        end
        req_valid = 1'b0;
        for (int k = 6; k < 8; k++) begin
            chk("pp_tail_valid", mc_valid, 1'b1);
            chk("pp_tail_addr", mc_addr, 32'h200 + k);
            tick();
        end
        mc_ready = 1'b0;
        chk("pp_count0", count, 0);

        // Reset while a read is outstanding
        set_req(1'b0, 32'h300, 32'h0);
        tick();
        req_valid = 1'b0;
        wait_valid("mr_issue", 4);
        mc_ready = 1'b1;
        tick();
        mc_ready = 1'b0;
        set_req(1'b1, 32'h304, 32'h77);
        tick();
        tick();
        req_valid = 1'b0;
        chk("mr_pre_count", count, 2);
        chk("mr_pre_mcv", mc_valid, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_count", count, 0);
        chk("mr_mcv", mc_valid, 1'b0);
        chk("mr_ready", req_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        mc_rvalid = 1'b1;
        mc_rdata  = 32'hDEAD;
        tick();
        mc_rvalid = 1'b0;
        chk("mr_no_rsp", rsp_valid, 1'b0);
        tick();
        chk("mr_no_rsp2", rsp_valid, 1'b0);
        chk("mr_idle_mcv", mc_valid, 1'b0);
        chk("mr_idle_count", count, 0);

        // Read with no return data, a write queued behind it
        set_req(1'b0, 32'h400, 32'h0);
        tick();
        req_valid = 1'b0;
        wait_valid("tmo_issue", 4);
        mc_ready = 1'b1;
        set_req(1'b1, 32'h404, 32'h55);
        tick();
        req_valid = 1'b0;
        mc_ready  = 1'b0;
`ifdef MEMQ_RD_TIMEOUT_EN
        n = 0;
        while (rsp_err !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, RD_TIMEOUT);
        chk("tmo_no_rsp", rsp_valid, 1'b0);
        tick();
        chk("tmo_err_pulse", rsp_err, 1'b0);
`else
        errs = 0;
        valids = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            errs   += (rsp_err === 1'b1) ? 1 : 0;
            valids += (mc_valid === 1'b1 || rsp_valid === 1'b1) ? 1 : 0;
        end
        chk("wait_no_err", errs, 0);
        chk("wait_held", valids, 0);
        mc_rvalid = 1'b1;
        mc_rdata  = 32'h5A5A;
        tick();
        mc_rvalid = 1'b0;
        chk("late_rsp_valid", rsp_valid, 1'b1);
        chk("late_rsp_data", rsp_data, 32'h5A5A);
        tick();
`endif
        chk("next_issue", mc_valid, 1'b1);
        chk("next_addr", mc_addr, 32'h404);
        mc_ready = 1'b1;
        tick();
        mc_ready = 1'b0;
        chk("next_count0", count, 0);

        // Randomized traffic against the reference queue
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        q.delete();
        rd_out  = 1'b0;
        exp_rsp = 1'b0;
        exp_rdata = '0;
        stall = 0;
        for (int i = 0; i < 600; i++) begin
            chk("rnd_count", count, q.size());
            chk("rnd_ready", req_ready, (q.size() < DEPTH));
            chk("rnd_rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp) begin
                chk("rnd_rsp_data", rsp_data, exp_rdata);
            end
            chk("rnd_rsp_err", rsp_err, 1'b0);
            if (mc_valid === 1'b1) begin
                chk("rnd_issue_ok", (q.size() > 0 && !rd_out), 1'b1);
                if (q.size() > 0) begin
                    chk("rnd_mc_write", mc_write, q[0].w);
                    chk("rnd_mc_addr", mc_addr, q[0].a);
                    if (q[0].w) begin
                        chk("rnd_mc_wdata", mc_wdata, q[0].d);
                    end
                end
            end
            if (q.size() > 0 && !rd_out && mc_valid !== 1'b1) begin
                stall++;
            end else begin
                stall = 0;
            end
            chk("rnd_stall", (stall <= 1), 1'b1);

            req_valid = ($urandom_range(1, 0) == 1);
            req_write = ($urandom_range(1, 0) == 1);
            req_addr  = $urandom;
            req_wdata = $urandom;
            mc_ready  = ($urandom_range(2, 0) != 0);
            mc_rvalid = rd_out ? ($urandom_range(3, 0) == 0) : ($urandom_range(7, 0) == 0);
            mc_rdata  = $urandom;

            do_push = req_valid && (q.size() < DEPTH);
            do_pop  = (mc_valid === 1'b1) && mc_ready;
            exp_rsp = rd_out && mc_rvalid;
            if (exp_rsp) begin
                exp_rdata = mc_rdata;
                rd_out = 1'b0;
            end
            if (do_pop && q.size() > 0) begin
                if (!q[0].w) begin
                    rd_out = 1'b1;
                end
                void'(q.pop_front());
            end
            if (do_push) begin
                ent.w = req_write;
                ent.a = req_addr;
                ent.d = req_wdata;
                q.push_back(ent);
            end
            tick();
        end
        req_valid = 1'b0;
        mc_ready  = 1'b0;
        mc_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_req_queue.md
MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
- REQ-001 Parameter ADDR_W, default 32, address width of requests.
- REQ-002 Parameter DATA_W, default 32, write/read data width.
- REQ-003 Parameter DEPTH, default 4, request FIFO entries; power of two, 2..16.
- REQ-004 Parameter RD_TIMEOUT, default 64, cycles allowed in WAIT_RD before abort; used only with MEMQ_RD_TIMEOUT_EN.
- REQ-005 clk  in  1  single clock; all state updates on posedge.
- REQ-006 reset  in  1  asynchronous, active-low reset.
- REQ-007 req_valid  in  1  client request present.
- REQ-008 req_ready  out  1  queue can accept; equals FIFO not full.
- REQ-009 req_write  in  1  1 = write, 0 = read.
- REQ-010 req_addr  in  ADDR_W  request address.
- REQ-011 req_wdata  in  DATA_W  write data; ignored for reads.
- REQ-012 mc_valid  out  1  request presented to memory controller.
- REQ-013 mc_ready  in  1  memory controller accepts the presented request.
- REQ-014 mc_write, mc_addr, mc_wdata  out  1/ADDR_W/DATA_W  head entry fields.
- REQ-015 mc_rvalid  in  1  read data returned, one-cycle pulse.
- REQ-016 mc_rdata  in  DATA_W  read data.
- REQ-017 rsp_valid  out  1  one-cycle pulse, read response to client.
- REQ-018 rsp_data  out  DATA_W  registered read data.
- REQ-019 rsp_err  out  1  one-cycle pulse, read aborted by timeout.
- REQ-020 count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
- REQ-021 Push at a posedge where req_valid && req_ready; the entry {write, addr, wdata} is stored at the write pointer.
- REQ-022 Read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH; req_ready=0 when count==DEPTH; no bypass of a full FIFO.
- REQ-023 Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- REQ-024 FSM states: IDLE, ISSUE, WAIT_RD; encoding internal.
- REQ-025 IDLE: if count!=0 go to ISSUE, else stay.
- REQ-026 ISSUE: mc_valid=1, mc_* driven from head entry and held stable until mc_ready.
- REQ-027 ISSUE with mc_ready and head is a write: pop; next state ISSUE if count>1, else IDLE (back-to-back writes, one per cycle).
- REQ-028 ISSUE with mc_ready and head is a read: pop; go to WAIT_RD; at most one outstanding read.
- REQ-029 WAIT_RD: mc_valid=0; on mc_rvalid, rsp_data<=mc_rdata, rsp_valid pulses the following cycle, go to IDLE.
- REQ-030 mc_rvalid outside WAIT_RD is ignored; no rsp_valid.
- REQ-031 Minimum latency: entry pushed at edge N -> mc_valid high after edge N+1.
- REQ-032 Pushes continue in all states while not full.

Reset
- REQ-033 Reset asserted (low) asynchronously clears pointers, count=0, state=IDLE, mc_valid=0, mc_write=0, mc_addr=0, mc_wdata=0, rsp_valid=0, rsp_data=0, rsp_err=0, timeout counter=0.
- REQ-034 req_ready=1 during and after reset.
- REQ-035 Reset mid-read discards the outstanding read and all queued entries; a later mc_rvalid is ignored.

Configuration
- REQ-036 Macro MEMQ_RD_TIMEOUT_EN defined: counter runs in WAIT_RD; after RD_TIMEOUT cycles without mc_rvalid, rsp_err pulses one cycle, rsp_valid stays 0, state goes to IDLE; mc_rvalid on the same edge as expiry wins.
- REQ-037 Macro not defined: no counter logic, rsp_err tied 0, WAIT_RD waits indefinitely.

Verification
- REQ-038 Write A=0x10 D=0xCAFE, mc_ready=1 -> mc_valid high after 2nd edge, mc_addr=0x10, mc_wdata=0xCAFE, count returns to 0.
- REQ-039 Read A=0x20, mc_rvalid with 0x1234 three cycles later -> rsp_valid one cycle, rsp_data=0x1234.
- REQ-040 Five writes with mc_ready=0 -> req_ready=0 after 4th, count=4; release mc_ready -> four mc handshakes in consecutive cycles, in order.
- REQ-041 Push while popping at count=2 -> count stays 2; pointers wrap after 8 total entries with data order preserved.
- REQ-042 Reset low during WAIT_RD, then mc_rvalid -> no rsp_valid, count=0, state IDLE.
- REQ-043 With MEMQ_RD_TIMEOUT_EN, read with no mc_rvalid -> rsp_err pulse after 64 cycles, next request issues.
